// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, Rx assembler state encodings and
// the saturating increment used by both the Rx and Tx statistics blocks.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int BIT_IDX_W   = 4;

  typedef enum logic [1:0] {
    ASM_IDLE     = 2'd0,
    ASM_COLLECT  = 2'd1,
    ASM_WAIT_END = 2'd2
  } asm_state_e;

  // Callers size the result back down to their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry lives in its own
// register so the read data path comes straight from a flop.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] head
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W-1:0] rd_idx_next;
  logic              do_push;
  logic              do_pop;

  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign do_pop      = pop & ~empty;
  assign do_push     = push & (~full | do_pop);
  assign rd_idx_next = rd_ptr[ADDR_W-1:0] + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CNT_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= din;
  end

  // A byte landing in a FIFO that is (or is about to be) empty bypasses the
  // array; otherwise a pop refills the head from the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (do_push && (empty || (do_pop && count == CNT_ONE))) begin
      head <= din;
    end else if (do_pop && count > CNT_ONE) begin
      head <= mem[rd_idx_next];
    end
  end

endmodule

// File: rtl/uart_rx_byte_buffer.sv
// Rebuilds received bytes from per-bit decisions, commits good frames into a
// FWFT FIFO and keeps saturating frame-error / drop statistics.
module uart_rx_byte_buffer
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_bit_valid,
  input  logic                 i_bit,
  input  logic [BIT_IDX_W-1:0] i_bit_idx,
  input  logic                 i_rx_complete,
  input  logic                 i_rx_error,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ADDR_W:0]      o_count,
  output logic                 o_overflow,
  output logic [CNT_W-1:0]     o_frame_err_cnt,
  output logic [CNT_W-1:0]     o_drop_cnt,
  input  logic                 i_clr_status
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  asm_state_e             asm_state;
  asm_state_e             asm_state_nxt;
  logic [DATA_W-1:0]      shadow;
  logic [DATA_W-1:0]      shadow_nxt;
  logic [BIT_IDX_W-1:0]   exp_idx;
  logic [BIT_IDX_W-1:0]   exp_idx_nxt;
  logic                   bad;
  logic                   bad_nxt;
  logic                   commit;
  logic                   err_evt;
  logic                   frame_end;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   drop;

  assign frame_end = i_rx_complete | i_rx_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= ASM_IDLE;
      shadow    <= '0;
      exp_idx   <= '0;
      bad       <= 1'b0;
    end else begin
      asm_state <= asm_state_nxt;
      shadow    <= shadow_nxt;
      exp_idx   <= exp_idx_nxt;
      bad       <= bad_nxt;
    end
  end

  // A frame end takes priority over a bit strobe in the same cycle; error
  // wins over complete when both arrive together.
  always_comb begin
    asm_state_nxt = asm_state;
    shadow_nxt    = shadow;
    exp_idx_nxt   = exp_idx;
    bad_nxt       = bad;
    commit        = 1'b0;
    err_evt       = 1'b0;
    case (asm_state)
      ASM_IDLE: begin
        if (frame_end) begin
          err_evt = 1'b1;
        end else if (i_bit_valid) begin
          asm_state_nxt = ASM_COLLECT;
          if (i_bit_idx == '0) begin
            shadow_nxt[0] = i_bit;
            exp_idx_nxt   = BIT_IDX_W'(1);
            bad_nxt       = 1'b0;
          end else begin
            exp_idx_nxt   = '0;
            bad_nxt       = 1'b1;
          end
        end
      end
      ASM_COLLECT: begin
        if (frame_end) begin
          // Any end while still collecting is either an error or a short frame.
          err_evt       = 1'b1;
          asm_state_nxt = ASM_IDLE;
        end else if (i_bit_valid) begin
          if (i_bit_idx == exp_idx) begin
            for (int b = 0; b < DATA_W; b++) begin
              if (i_bit_idx == BIT_IDX_W'(b)) shadow_nxt[b] = i_bit;
            end
            exp_idx_nxt = exp_idx + BIT_IDX_W'(1);
            if (exp_idx == BIT_IDX_W'(DATA_W - 1)) asm_state_nxt = ASM_WAIT_END;
          end else begin
            bad_nxt = 1'b1;
          end
        end
      end
      ASM_WAIT_END: begin
        if (frame_end) begin
          asm_state_nxt = ASM_IDLE;
          if (i_rx_error || bad) err_evt = 1'b1;
          else                   commit  = 1'b1;
        end else if (i_bit_valid) begin
          bad_nxt = 1'b1;
        end
      end
      default: asm_state_nxt = ASM_IDLE;
    endcase
  end

  assign pop     = o_valid & i_ready;
  assign drop    = commit & fifo_full & ~pop;
  assign o_valid = ~fifo_empty;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (commit),
    .din   (shadow),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count),
    .head  (o_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frame_err_cnt <= '0;
      o_drop_cnt      <= '0;
      o_overflow      <= 1'b0;
    end else if (i_clr_status) begin
      o_frame_err_cnt <= '0;
      o_drop_cnt      <= '0;
      o_overflow      <= 1'b0;
    end else begin
      if (err_evt) o_frame_err_cnt <= CNT_W'(sat_inc(32'(o_frame_err_cnt), 32'(CNT_MAX)));
      if (drop) begin
        o_drop_cnt <= CNT_W'(sat_inc(32'(o_drop_cnt), 32'(CNT_MAX)));
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte_buffer.sv
// Scenario-driven bench for uart_rx_byte_buffer: bytes expected at the output
// are queued when their frames are driven and matched as the consumer pops.
module tb_uart_rx_byte_buffer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 8;
  localparam int CMAX   = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_bit_valid;
  logic              i_bit;
  logic [3:0]        i_bit_idx;
  logic              i_rx_complete;
  logic              i_rx_error;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic [CNT_W-1:0]  o_frame_err_cnt;
  logic [CNT_W-1:0]  o_drop_cnt;
  logic              i_clr_status;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_exp;
  int                n_cmp = 0;
  int                n_fail = 0;
  int                exp_err = 0;
  int                exp_drop = 0;
  logic              exp_ovf = 1'b0;
  bit                rand_ready = 1'b0;

  always #5 clk = ~clk;

  uart_rx_byte_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_bit_valid     (i_bit_valid),
    .i_bit           (i_bit),
    .i_bit_idx       (i_bit_idx),
    .i_rx_complete   (i_rx_complete),
    .i_rx_error      (i_rx_error),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_count         (o_count),
    .o_overflow      (o_overflow),
    .o_frame_err_cnt (o_frame_err_cnt),
    .o_drop_cnt      (o_drop_cnt),
    .i_clr_status    (i_clr_status)
  );

  // Inputs change at posedge+1, so the negedge sees the handshake that the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_order: got byte %h, no byte expected", o_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_data !== mon_exp) begin
          n_fail++;
          $display("FAIL pop_order: got %h, expected %h", o_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    i_bit_valid   = 1'b0;
    i_rx_complete = 1'b0;
    i_rx_error    = 1'b0;
    i_clr_status  = 1'b0;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      i_bit_valid = 1'b1;
      i_bit_idx   = 4'(i);
      i_bit       = d[i];
    end
  endtask

  task automatic end_good(input logic [7:0] d, input bit pop_now);
    step();
    i_rx_complete = 1'b1;
    if (pop_now) i_ready = 1'b1;
    if (exp_q.size() < DEPTH || (i_ready && exp_q.size() > 0)) begin
      exp_q.push_back(d);
    end else begin
      if (exp_drop < CMAX) exp_drop++;
      exp_ovf = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(d, 8);
    end_good(d, 1'b0);
  endtask

  task automatic send_err_frame(input logic [7:0] d);
    send_bits(d, 8);
    step();
    i_rx_error = 1'b1;
    if (exp_err < CMAX) exp_err++;
  endtask

  task automatic drain();
    int guard;
    guard   = 0;
    i_ready = 1'b1;
    while (exp_q.size() > 0 && guard < 300) begin
      step();
      guard++;
    end
    i_ready = 1'b0;
    step();
    n_cmp++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
    end
    n_cmp++;
    if (o_count !== 5'd0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: count=%0d valid=%b, expected 0/0", o_count, o_valid);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    i_bit_valid   = 1'b0;
    i_bit         = 1'b0;
    i_bit_idx     = 4'd0;
    i_rx_complete = 1'b0;
    i_rx_error    = 1'b0;
    i_ready       = 1'b0;
    i_clr_status  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (o_valid !== 1'b0 || o_data !== 8'h00 || o_count !== 5'd0 || o_overflow !== 1'b0 ||
        o_frame_err_cnt !== 8'd0 || o_drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h count=%0d ovf=%b err=%0d drop=%0d, expected all 0",
               o_valid, o_data, o_count, o_overflow, o_frame_err_cnt, o_drop_cnt);
    end
  endtask

  task automatic test_basic_byte();
    send_frame(8'hA5);
    step();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 8'hA5 || o_count !== 5'd1) begin
      n_fail++;
      $display("FAIL latency_a5: valid=%b data=%h count=%0d, expected 1/a5/1", o_valid, o_data, o_count);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    n_cmp++;
    if (o_count !== 5'd0 || o_valid !== 1'b0 || o_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL pop_a5: count=%0d valid=%b data=%h, expected 0/0/a5 held", o_count, o_valid, o_data);
    end
  endtask

  task automatic test_stop_error();
    send_err_frame(8'h5A);
    step();
    n_cmp++;
    if (o_count !== 5'd0 || o_frame_err_cnt !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL stop_error: count=%0d err=%0d, expected 0/%0d", o_count, o_frame_err_cnt, exp_err);
    end
    send_frame(8'h3C);
    step();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL after_error_3c: valid=%b data=%h, expected 1/3c", o_valid, o_data);
    end
    drain();
  endtask

  task automatic test_malformed();
    logic [3:0] seq [7];
    seq = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    for (int i = 0; i < 7; i++) begin
      step();
      i_bit_valid = 1'b1;
      i_bit_idx   = seq[i];
      i_bit       = 1'(i);
    end
    step();
    i_rx_complete = 1'b1;
    exp_err++;
    send_bits(8'hFF, 5);
    step();
    i_rx_complete = 1'b1;
    exp_err++;
    step();
    i_rx_complete = 1'b1;
    exp_err++;
    step();
    n_cmp++;
    if (o_frame_err_cnt !== 8'(exp_err) || o_count !== 5'd0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL malformed: err=%0d count=%0d valid=%b, expected %0d/0/0",
               o_frame_err_cnt, o_count, o_valid, exp_err);
    end
    send_frame(8'h96);
    drain();
  endtask

  task automatic test_full();
    i_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)));
    step();
    n_cmp++;
    if (o_count !== 5'd16 || o_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL fill_16: count=%0d data=%h, expected 16/%h", o_count, o_data, exp_q[0]);
    end
    send_frame(8'hEE);
    step();
    n_cmp++;
    if (o_overflow !== exp_ovf || o_drop_cnt !== 8'(exp_drop) || o_count !== 5'd16) begin
      n_fail++;
      $display("FAIL overflow_drop: ovf=%b drop=%0d count=%0d, expected %b/%0d/16",
               o_overflow, o_drop_cnt, o_count, exp_ovf, exp_drop);
    end
    send_bits(8'h77, 8);
    end_good(8'h77, 1'b1);
    step();
    i_ready = 1'b0;
    n_cmp++;
    if (o_count !== 5'd16 || o_drop_cnt !== 8'(exp_drop)) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d drop=%0d, expected 16/%0d", o_count, o_drop_cnt, exp_drop);
    end
    drain();
    step();
    i_clr_status = 1'b1;
    exp_ovf  = 1'b0;
    exp_drop = 0;
    exp_err  = 0;
    step();
    n_cmp++;
    if (o_overflow !== 1'b0 || o_drop_cnt !== 8'd0 || o_frame_err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_status: ovf=%b drop=%0d err=%0d, expected 0/0/0",
               o_overflow, o_drop_cnt, o_frame_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_frame(8'($urandom_range(0, 255)));
    rand_ready = 1'b0;
    drain();
    n_cmp++;
    if (o_overflow !== exp_ovf || o_drop_cnt !== 8'(exp_drop)) begin
      n_fail++;
      $display("FAIL stream_stats: ovf=%b drop=%0d, expected %b/%0d", o_overflow, o_drop_cnt, exp_ovf, exp_drop);
    end
  endtask

  task automatic test_mid_frame_reset();
    i_ready = 1'b0;
    send_frame(8'hC3);
    step();
    i_rx_error = 1'b1;
    send_bits(8'h0F, 4);
    #2;
    i_bit_valid = 1'b0;
    rst_n       = 1'b0;
    exp_q.delete();
    exp_err  = 0;
    exp_drop = 0;
    exp_ovf  = 1'b0;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_data !== 8'h00 || o_count !== 5'd0 || o_overflow !== 1'b0 ||
        o_frame_err_cnt !== 8'd0 || o_drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b data=%h count=%0d ovf=%b err=%0d drop=%0d, expected all 0",
               o_valid, o_data, o_count, o_overflow, o_frame_err_cnt, o_drop_cnt);
    end
    step();
    rst_n = 1'b1;
    send_frame(8'h81);
    step();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 8'h81 || o_count !== 5'd1 || o_frame_err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_frame: valid=%b data=%h count=%0d err=%0d, expected 1/81/1/0",
               o_valid, o_data, o_count, o_frame_err_cnt);
    end
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) send_err_frame(8'($urandom_range(0, 255)));
    step();
    n_cmp++;
    if (o_frame_err_cnt !== 8'd255 || exp_err != CMAX) begin
      n_fail++;
      $display("FAIL err_saturate: err=%0d, expected 255", o_frame_err_cnt);
    end
    step();
    i_rx_error   = 1'b1;
    i_clr_status = 1'b1;
    exp_err      = 0;
    step();
    n_cmp++;
    if (o_frame_err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_wins: err=%0d, expected 0", o_frame_err_cnt);
    end
    i_rx_error = 1'b1;
    exp_err    = 1;
    step();
    n_cmp++;
    if (o_frame_err_cnt !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL err_after_clear: err=%0d, expected %0d", o_frame_err_cnt, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_byte();
    test_stop_error();
    test_malformed();
    test_full();
    test_back_to_back();
    test_mid_frame_reset();
    test_saturation();
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected bytes never popped", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
